// File: rtl/fifo_sync_lvl.sv
// fifo_sync_lvl: single-clock FIFO with occupancy count, almost-full/almost-empty
// watermarks and a registered or FWFT read port; FIFO_ERR_FLAGS_EN adds sticky error flags.
module fifo_sync_lvl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WE,
  input  logic                   RE,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
`endif
);

  localparam int ADDR = $clog2(DEPTH);
  localparam int CW   = ADDR + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] PTR_ONE = {{ADDR{1'b0}}, 1'b1};

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_lvl: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("fifo_sync_lvl: AF_LEVEL must be in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("fifo_sync_lvl: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    wr_ptr_r;
  logic [CW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_s;
  logic             full_s;
  logic             empty_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic [WIDTH-1:0] head_s;

  // Extra pointer MSB distinguishes full from empty, so occupancy is the plain difference.
  assign count_s      = wr_ptr_r - rd_ptr_r;
  assign full_s       = (count_s == DEPTH_C);
  assign empty_s      = (count_s == {CW{1'b0}});
  assign wr_acc_s     = WE && !full_s;
  assign rd_acc_s     = RE && !empty_s;
  assign head_s       = mem_r[rd_ptr_r[ADDR-1:0]];

  assign count        = count_s;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_s >= AF_C);
  assign almost_empty = (count_s <= AE_C);

  // Storage array; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[ADDR-1:0]] <= din;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {CW{1'b0}};
      rd_ptr_r <= {CW{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; forced to zero while nothing is stored.
    always_comb begin
      dout = {WIDTH{1'b0}};
      if (empty_s) begin
        dout = {WIDTH{1'b0}};
      end else begin
        dout = head_s;
      end
    end
  end else begin : g_reg
    logic [WIDTH-1:0] dout_r;
    // Registered read port, loads only on an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_r <= {WIDTH{1'b0}};
      end else if (rd_acc_s) begin
        dout_r <= head_s;
      end else begin
        dout_r <= dout_r;
      end
    end
    assign dout = dout_r;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a new event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (WE && full_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (RE && empty_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

endmodule

// File: doc/fifo_sync_lvl.md
Name: fifo_sync_lvl

Overview:
Parametrised single-clock FIFO, successor to the basic UART TX/RX FIFO. Adds:
- an occupancy count output
- programmable almost-full and almost-empty thresholds
- a selectable first-word-fall-through (FWFT) read mode
- optional sticky overflow/underflow error flags

It sits between the UART byte engines and the host-side bus, and replaces the plain FIFO where flow-control watermarks are needed.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of storage entries; power of two, >=2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- clk, in, 1, single clock; all state changes on its rising edge
- rst_n, in, 1, asynchronous active-low reset
- WE, in, 1, write request
- RE, in, 1, read request
- din, in, WIDTH, write data
- dout, out, WIDTH, read data
- full, out, 1, count == DEPTH
- empty, out, 1, count == 0
- almost_full, out, 1, count >= AF_LEVEL
- almost_empty, out, 1, count <= AE_LEVEL
- count, out, $clog2(DEPTH)+1, current occupancy, 0..DEPTH
- overflow, out, 1, sticky: write attempted while full (only when FIFO_ERR_FLAGS_EN is defined)
- underflow, out, 1, sticky: read attempted while empty (only when FIFO_ERR_FLAGS_EN is defined)
- clr_err, in, 1, synchronous clear of overflow/underflow (only when FIFO_ERR_FLAGS_EN is defined)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low. Assertion acts immediately, regardless of clk.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, dout=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not reset.
- Reset mid-operation discards all stored words. The first accepted write after release is the only readable word.
- Pointers:
  - ADDR+1 bits each, ADDR = $clog2(DEPTH); low ADDR bits index memory.
  - Wrap from DEPTH-1 to 0 flips the MSB. No special case at wrap.
- Write accepted iff WE && !full: MEM[wr_ptr] <= din, wr_ptr+1.
- Read accepted iff RE && !empty: rd_ptr+1.
- count next value:
  - +1 on accepted write only
  - -1 on accepted read only
  - unchanged on both or neither
- Flags are derived combinationally from registered count, so they update in the cycle after the causing edge's inputs.
- Simultaneous WE and RE:
  - When full: read accepted, write rejected, count = DEPTH-1 next.
  - When empty: write accepted, read rejected, count = 1 next.
  - Otherwise: both accepted, count unchanged.
- FWFT=0: dout is registered. It loads MEM[rd_ptr] on an accepted read, so data appears 1 cycle after the RE edge. dout holds its value on no read, rejected read, or a write.
- FWFT=1:
  - dout = MEM[rd_ptr] combinationally while !empty, and 0 while empty.
  - A word written on edge N is on dout after edge N, in the same cycle empty deasserts.
  - An accepted read advances dout to the next word after the edge.
- Parameter violations (DEPTH not a power of two, AF_LEVEL or AE_LEVEL out of range) are rejected at elaboration with $error.

Optional Feature:
FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any edge with WE && full; underflow sets on any edge with RE && empty.
  - Both flags are sticky until an edge with clr_err=1.
  - If clr_err coincides with a new error event, set wins.
  - Rejected accesses never modify pointers, memory, dout or count.
- Not defined: overflow, underflow and clr_err ports are absent. Rejected accesses are silently ignored.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, almost_empty=1, full=0, almost_full=0, count=0, dout=0.
- FWFT=0: write 0xA5 then 0x3C; assert RE for 2 cycles -> dout=0xA5 one cycle after first RE edge, then 0x3C; count goes 2,1,0; empty=1 after second read.
- Write 16 words 0x00..0x0F -> almost_full=1 at count=14, full=1 at count=16. Write 0x55 while full -> count stays 16, overflow=1 (with FIFO_ERR_FLAGS_EN). Read all 16 -> data 0x00..0x0F, with 0x55 never seen.
- Keep 4 words resident; run 40 cycles of simultaneous WE+RE with incrementing data -> count constant at 4, ordering preserved across 2+ pointer wraps.
- FWFT=1: write 0x7E to empty FIFO -> dout=0x7E and empty=0 after that edge. RE on empty FIFO -> no pointer change, underflow=1. Then clr_err=1 -> underflow=0 next edge.
- Fill to 10 words, pulse rst_n low mid-cycle -> all outputs return to reset values immediately. The next write and read returns only the new word.
